// File: rtl/ysyx_24110015_ifu_prefetch.sv
// Instruction fetch unit: sequential PC fetch, prefetch FIFO, redirect flush.
// Ports: clk/rst, redirect_*, mem_req_*/mem_resp_* memory port, out_* to IDU.
module ysyx_24110015_ifu_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
  localparam logic [CW:0]   DEP_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   out_cnt_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [CW:0]     credit;

  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] inst_q [DEPTH];
  logic            flt_q  [DEPTH];

  logic req_fire;
  logic resp_drop;
  logic push;
  logic pop;
  logic unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];

  // credit counts FIFO entries plus every outstanding request,
  // so each response is guaranteed a free slot
  assign credit = {1'b0, fifo_cnt} + {1'b0, out_cnt};

  assign mem_req_valid = !rst
                      && state == RUN
                      && !redirect_valid
                      && out_cnt < MAX_C
                      && credit < DEP_C;

  assign mem_req_addr = fetch_pc;

  assign req_fire  = mem_req_valid && mem_req_ready;
  assign resp_drop = mem_resp_valid && drop_cnt != '0;
  assign push      = mem_resp_valid && drop_cnt == '0
                  && !redirect_valid;

  assign out_valid = !rst && fifo_cnt != '0;
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign out_pc    = out_valid ? pc_q[rptr]   : '0;
  assign out_inst  = out_valid ? inst_q[rptr] : '0;
  assign out_fault = out_valid && flt_q[rptr];

  always_comb begin
    out_cnt_nxt = out_cnt;
    unique case ({req_fire, mem_resp_valid})
      2'b10:   out_cnt_nxt = out_cnt + ONE_C;
      2'b01:   out_cnt_nxt = out_cnt - ONE_C;
      default: out_cnt_nxt = out_cnt;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (redirect_valid)
          state_nxt = RUN;
        else if (push && mem_resp_err)
          state_nxt = STALL;
      end
      STALL: begin
        if (redirect_valid)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      rptr     <= '0;
      wptr     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      resp_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
      out_cnt  <= out_cnt_nxt;
      // out_cnt already includes responses marked for
      // dropping, so it alone is the new discard count
      drop_cnt <= out_cnt_nxt;
      fifo_cnt <= '0;
      rptr     <= '0;
      wptr     <= '0;
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + XLEN'(4);
      out_cnt <= out_cnt_nxt;
      if (resp_drop)
        drop_cnt <= drop_cnt - ONE_C;
      if (push) begin
        resp_pc <= resp_pc + XLEN'(4);
        wptr    <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + ONE_C;
        2'b01:   fifo_cnt <= fifo_cnt - ONE_C;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_q[wptr]   <= resp_pc;
      inst_q[wptr] <= mem_resp_err ? '0 : mem_resp_data;
      flt_q[wptr]  <= mem_resp_err;
    end
  end

  resp_has_req: assert property (
    @(posedge clk) disable iff (rst)
    !(mem_resp_valid && out_cnt == '0)
  ) else $error("ifu: response with no outstanding request");

endmodule

// File: tb/tb_ysyx_24110015_ifu_prefetch.sv
// Testbench for ysyx_24110015_ifu_prefetch: random memory/IDU behaviour
// against a queue-based reference of the fetch stream, plus directed cases.
module tb_ysyx_24110015_ifu_prefetch;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  always #5 clk = ~clk;

  ysyx_24110015_ifu_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        f;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  ent_t        mq[$];
  req_t        pend[$];
  logic [31:0] popped[$];
  logic [31:0] m_fetch;
  logic [31:0] m_resp;
  int          m_drop;
  bit          m_stall;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_req = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] flt_addr = 32'h1;
  bit          rnd_flt = 1'b0;
  bit          saw_fault;
  logic [31:0] fault_pc;
  logic [31:0] fault_inst;

  function automatic logic [31:0] memd(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h1357_2468;
  endfunction

  function automatic bit is_flt(input logic [31:0] a);
    return (a == flt_addr) || (rnd_flt && a[7:2] == 6'h15);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic mreset();
    mq.delete();
    pend.delete();
    m_fetch   = RPC;
    m_resp    = RPC;
    m_drop    = 0;
    m_stall   = 1'b0;
    last_due  = cyc;
    saw_fault = 1'b0;
  endtask

  task automatic step(input bit rdy, input bit ordy,
                      input bit redir, input logic [31:0] rpc);
    bit   rv;
    bit   exp_rv;
    bit   fire;
    req_t r;
    ent_t e;
    int   d;
    @(negedge clk);
    rv = pend.size() > 0 && pend[0].due <= cyc;
    mem_resp_valid = rv;
    mem_resp_data  = rv ? memd(pend[0].addr) : 32'h0;
    mem_resp_err   = rv ? is_flt(pend[0].addr) : 1'b0;
    mem_req_ready  = rdy;
    out_ready      = ordy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    exp_rv = !m_stall && !redir && pend.size() < 2
          && (mq.size() + pend.size()) < 4;
    check("req_valid", 32'(mem_req_valid), 32'(exp_rv));
    if (exp_rv)
      check("req_addr", mem_req_addr, m_fetch);
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0 && out_valid) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_inst", out_inst, mq[0].inst);
      check("out_fault", 32'(out_fault), 32'(mq[0].f));
    end
    fire = mem_req_valid && rdy;
    if (ordy && out_valid && !redir) begin
      popped.push_back(out_pc);
      if (out_fault && !saw_fault) begin
        saw_fault  = 1'b1;
        fault_pc   = out_pc;
        fault_inst = out_inst;
      end
    end
    if (ordy && mq.size() > 0 && !redir)
      void'(mq.pop_front());
    if (rv) begin
      r = pend.pop_front();
      if (m_drop > 0) begin
        m_drop--;
      end else begin
        e.pc   = m_resp;
        e.f    = is_flt(r.addr);
        e.inst = e.f ? 32'h0 : memd(r.addr);
        mq.push_back(e);
        m_resp += 32'd4;
        if (e.f)
          m_stall = 1'b1;
      end
    end
    if (redir) begin
      mq.delete();
      m_fetch = {rpc[31:2], 2'b00};
      m_resp  = m_fetch;
      m_drop  = pend.size();
      m_stall = 1'b0;
    end
    if (fire) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due)
        d = last_due + 1;
      last_due = d;
      r.addr = mem_req_addr;
      r.due  = d;
      pend.push_back(r);
      m_fetch += 32'd4;
      n_req++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    cyc++;
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_req_valid", 32'(mem_req_valid), 32'h0);
    check("rst_addr", mem_req_addr, RPC);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_fault", 32'(out_fault), 32'h0);
    rst = 1'b0;
    cyc++;
    mreset();
    #1;
    check("first_req", 32'(mem_req_valid), 32'h1);
    check("first_addr", mem_req_addr, RPC);
  endtask

  initial begin
    int          n0;
    logic [31:0] rpc;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    mem_resp_err   = 1'b0;
    out_ready      = 1'b0;
    mreset();

    // streaming at one instruction per cycle
    do_reset();
    lat_min = 1;
    lat_max = 1;
    popped.delete();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b0, 32'h0);
    check("stream_pops", 32'(popped.size()), 32'd18);
    for (int i = 0; i < 3; i++)
      check("stream_pc", popped[i], RPC + 32'(4 * i));

    // IDU stalled: fill exactly DEPTH then stop
    do_reset();
    n0 = n_req;
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b0, 1'b0, 32'h0);
    check("fill_reqs", 32'(n_req - n0), 32'd4);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 32'h0);
    check("resume_reqs", 32'(n_req - n0 > 4), 32'h1);

    // redirect with two responses in flight
    do_reset();
    lat_min = 3;
    lat_max = 3;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("inflight", 32'(pend.size()), 32'd2);
    popped.delete();
    step(1'b1, 1'b1, 1'b1, 32'h8000_1002);
    for (int i = 0; i < 15; i++)
      step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_pops", 32'(popped.size() > 0), 32'h1);
    if (popped.size() > 0)
      check("redir_first_pc", popped[0], 32'h8000_1000);

    // access fault stalls fetch until redirect
    do_reset();
    lat_min  = 1;
    lat_max  = 1;
    flt_addr = 32'h8000_0008;
    n0 = n_req;
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 1'b0, 32'h0);
    check("fault_reqs", 32'(n_req - n0), 32'd4);
    check("fault_seen", 32'(saw_fault), 32'h1);
    check("fault_pc", fault_pc, 32'h8000_0008);
    check("fault_inst", fault_inst, 32'h0);
    flt_addr = 32'h1;
    n0 = n_req;
    step(1'b1, 1'b1, 1'b1, 32'h8000_0100);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 1'b0, 32'h0);
    check("fault_resume", 32'(n_req - n0 > 0), 32'h1);

    // memory not ready: address held, nothing outstanding
    do_reset();
    n0 = n_req;
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 32'h0);
    check("hold_reqs", 32'(n_req - n0), 32'd0);
    check("hold_addr", mem_req_addr, RPC);

    // reset while the FIFO is full
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_before_rst", 32'(mq.size()), 32'd4);
    do_reset();

    // randomized traffic
    rnd_flt = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        lat_min = 1;
        lat_max = $urandom_range(4, 1);
      end
      if ($urandom_range(9, 0) == 0)
        rpc = 32'hffff_fff0 | 32'($urandom_range(15, 0));
      else
        rpc = RPC + ($urandom & 32'h3ff);
      step($urandom_range(3, 0) != 0,
           $urandom_range(3, 0) != 0,
           $urandom_range(29, 0) == 0,
           rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
